uart_fifo_core: RTL and testbench

// - Parametrised full-duplex UART: built-in 16x-oversampling baud tick, TX and RX FSMs, TX/RX FIFOs.
// - Runtime-selectable divisor, data bits (5..8) and stop bits; per-byte RX error flags.
// - Sits between the board Rx/Tx pins and host logic; valid/ready on both data sides.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_fifo_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encodings and the RX FIFO word layout
// used by uart_fifo_core and its FIFO sub-module.
package uart_pkg;

    localparam int OVS       = 16;
    localparam int NBITS_MIN = 5;
    localparam int NBITS_MAX = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       par_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_word_t;

    function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
        if (n < 4'(NBITS_MIN)) return 4'(NBITS_MIN);
        if (n > 4'(NBITS_MAX)) return 4'(NBITS_MAX);
        return n;
    endfunction

    function automatic logic [7:0] data_mask(input logic [3:0] n);
        return 8'hFF >> (4'd8 - n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with extra-MSB pointers; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; outputs of empty FIFOs are masked by the user.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with 16x oversampled baud tick and TX/RX FIFOs.
// Parity generation/checking exists only when UART_PARITY_EN is defined.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic [3:0]       NBits,
    input  logic             TwoStop,
    input  logic             ParEn,
    input  logic             ParOdd,
    input  logic [7:0]       TxData,
    input  logic             TxValid,
    output logic             TxReady,
    output logic             TxBusy,
    output logic [7:0]       RxData,
    output logic             RxFrameErr,
    output logic             RxParErr,
    output logic             RxValid,
    input  logic             RxReady,
    output logic             RxOverrun,
    input  logic             Rx,
    output logic             Tx
);
    localparam logic [4:0] BIT_LAST   = 5'(OVS - 1);
    localparam logic [4:0] HALF_LAST  = 5'(OVS / 2 - 1);
    localparam logic [4:0] STOP2_LAST = 5'(2 * OVS - 1);

    logic par_en_cfg, par_odd_cfg;
`ifdef UART_PARITY_EN
    assign par_en_cfg  = ParEn;
    assign par_odd_cfg = ParOdd;
`else
    assign par_en_cfg  = 1'b0;
    assign par_odd_cfg = 1'b0;
`endif

    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    assign tick = (tick_cnt >= BaudDiv);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
    end

    logic       tx_full, tx_empty, tx_pop, tx_load;
    logic [7:0] tx_head, tx_masked;
    logic [3:0] tx_nb_cfg;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .Clk(Clk), .Rst_n(Rst_n), .push(TxValid && !tx_full), .wdata(TxData),
        .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign tx_nb_cfg = clamp_nbits(NBits);
    assign tx_masked = tx_head & data_mask(tx_nb_cfg);

    tx_state_t  tx_state, tx_state_n;
    logic [4:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [7:0] tx_shreg, tx_shreg_n;
    logic [3:0] tx_nbits, tx_nbits_n;
    logic       tx_two_stop, tx_two_stop_n, tx_par_en, tx_par_en_n;
    logic       tx_par_bit, tx_par_bit_n, tx_line, tx_line_n;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shreg    <= '0;
            tx_nbits    <= 4'(NBITS_MAX);
            tx_two_stop <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_line     <= 1'b1;
        end else begin
            tx_state    <= tx_state_n;
            tx_cnt      <= tx_cnt_n;
            tx_bit      <= tx_bit_n;
            tx_shreg    <= tx_shreg_n;
            tx_nbits    <= tx_nbits_n;
            tx_two_stop <= tx_two_stop_n;
            tx_par_en   <= tx_par_en_n;
            tx_par_bit  <= tx_par_bit_n;
            tx_line     <= tx_line_n;
        end
    end

    // A new frame loads from IDLE or straight out of STOP, so back-to-back frames have no gap.
    always_comb begin
        tx_state_n    = tx_state;
        tx_cnt_n      = tx_cnt;
        tx_bit_n      = tx_bit;
        tx_shreg_n    = tx_shreg;
        tx_nbits_n    = tx_nbits;
        tx_two_stop_n = tx_two_stop;
        tx_par_en_n   = tx_par_en;
        tx_par_bit_n  = tx_par_bit;
        tx_load       = 1'b0;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: if (tick && !tx_empty) tx_load = 1'b1;
            TX_START: if (tick) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            TX_DATA: if (tick) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shreg_n = tx_shreg >> 1;
                    tx_bit_n   = tx_bit + 3'd1;
                    if ({1'b0, tx_bit} == tx_nbits - 4'd1)
                        tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tick) begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = '0;
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
`endif
            TX_STOP: if (tick) begin
                if (tx_cnt == (tx_two_stop ? STOP2_LAST : BIT_LAST)) begin
                    if (!tx_empty) tx_load = 1'b1;
                    else begin
                        tx_state_n = TX_IDLE;
                        tx_cnt_n   = '0;
                    end
                end else tx_cnt_n = tx_cnt + 5'd1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_pop        = 1'b1;
            tx_state_n    = TX_START;
            tx_cnt_n      = '0;
            tx_bit_n      = '0;
            tx_shreg_n    = tx_masked;
            tx_nbits_n    = tx_nb_cfg;
            tx_two_stop_n = TwoStop;
            tx_par_en_n   = par_en_cfg;
            tx_par_bit_n  = (^tx_masked) ^ par_odd_cfg;
        end
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shreg_n[0];
            TX_PARITY: tx_line_n = tx_par_bit_n;
            default:   tx_line_n = 1'b1;
        endcase
    end

    assign Tx      = tx_line;
    assign TxReady = !tx_full;
    assign TxBusy  = (tx_state != TX_IDLE) || !tx_empty;

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t  rx_state, rx_state_n;
    logic [4:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shreg, rx_shreg_n;
    logic [3:0] rx_nbits, rx_nbits_n;
    logic       rx_par_en, rx_par_en_n, rx_par_odd, rx_par_odd_n;
    logic       rx_par_err, rx_par_err_n, rx_push, rx_overrun;
    rx_word_t   rx_word, rx_head;
    logic       rx_full, rx_empty;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_nbits   <= 4'(NBITS_MAX);
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_err <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shreg   <= rx_shreg_n;
            rx_nbits   <= rx_nbits_n;
            rx_par_en  <= rx_par_en_n;
            rx_par_odd <= rx_par_odd_n;
            rx_par_err <= rx_par_err_n;
            rx_overrun <= rx_push && rx_full && !RxReady;
        end
    end

    // START re-checks the line half a bit in to reject glitches; later samples are one bit apart.
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        rx_bit_n     = rx_bit;
        rx_shreg_n   = rx_shreg;
        rx_nbits_n   = rx_nbits;
        rx_par_en_n  = rx_par_en;
        rx_par_odd_n = rx_par_odd;
        rx_par_err_n = rx_par_err;
        rx_push      = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_sync) begin
                rx_state_n   = RX_START;
                rx_cnt_n     = '0;
                rx_bit_n     = '0;
                rx_shreg_n   = '0;
                rx_nbits_n   = clamp_nbits(NBits);
                rx_par_en_n  = par_en_cfg;
                rx_par_odd_n = par_odd_cfg;
                rx_par_err_n = 1'b0;
            end
            RX_START: if (tick) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                    rx_cnt_n   = '0;
                end else rx_cnt_n = rx_cnt + 5'd1;
            end
            RX_DATA: if (tick) begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n           = '0;
                    rx_shreg_n[rx_bit] = rx_sync;
                    rx_bit_n           = rx_bit + 3'd1;
                    if ({1'b0, rx_bit} == rx_nbits - 4'd1)
                        rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
                end else rx_cnt_n = rx_cnt + 5'd1;
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (tick) begin
                if (rx_cnt == BIT_LAST) begin
                    rx_par_err_n = ((^rx_shreg) ^ rx_par_odd) != rx_sync;
                    rx_state_n   = RX_STOP;
                    rx_cnt_n     = '0;
                end else rx_cnt_n = rx_cnt + 5'd1;
            end
`endif
            RX_STOP: if (tick) begin
                if (rx_cnt == BIT_LAST) begin
                    rx_push    = 1'b1;
                    rx_state_n = RX_IDLE;
                    rx_cnt_n   = '0;
                end else rx_cnt_n = rx_cnt + 5'd1;
            end
            default: rx_state_n = RX_IDLE;
        endcase
        rx_word.par_err   = rx_par_err;
        rx_word.frame_err = !rx_sync;
        rx_word.data      = rx_shreg;
    end

    uart_sync_fifo #(.WIDTH($bits(rx_word_t)), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .Clk(Clk), .Rst_n(Rst_n), .push(rx_push), .wdata(rx_word),
        .pop(RxReady), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign RxValid    = !rx_empty;
    assign RxData     = rx_empty ? 8'h00 : rx_head.data;
    assign RxFrameErr = !rx_empty && rx_head.frame_err;
    assign RxOverrun  = rx_overrun;
`ifdef UART_PARITY_EN
    assign RxParErr   = !rx_empty && rx_head.par_err;
`else
    assign RxParErr   = 1'b0;
    wire   unused_par = ^{ParEn, ParOdd, rx_head.par_err};
`endif

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed loopback and driven-line checks for uart_fifo_core
// at BaudDiv=3 (64 clocks per bit); parity cases follow UART_PARITY_EN.
module tb_uart_fifo_core;

`ifdef UART_PARITY_EN
    localparam int PAR_FRAME  = 704;
    localparam int BIT9_LEVEL = 0;
`else
    localparam int PAR_FRAME  = 640;
    localparam int BIT9_LEVEL = 1;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [15:0] BaudDiv = 16'd3;
    logic [3:0]  NBits = 4'd8;
    logic        TwoStop = 1'b0;
    logic        ParEn = 1'b0;
    logic        ParOdd = 1'b0;
    logic [7:0]  TxData = 8'h00;
    logic        TxValid = 1'b0;
    logic        TxReady, TxBusy, RxFrameErr, RxParErr, RxValid, RxOverrun, Tx;
    logic [7:0]  RxData;
    logic        RxReady = 1'b0;
    logic        loopback = 1'b1;
    logic        rxDrive = 1'b1;
    logic        rxLine;

    int checkCount = 0;
    int errorCount = 0;
    int overrunCount = 0;

    assign rxLine = loopback ? Tx : rxDrive;

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (RxOverrun === 1'b1) overrunCount++;

    uart_fifo_core #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .BaudDiv(BaudDiv), .NBits(NBits), .TwoStop(TwoStop),
        .ParEn(ParEn), .ParOdd(ParOdd), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .TxBusy(TxBusy), .RxData(RxData), .RxFrameErr(RxFrameErr),
        .RxParErr(RxParErr), .RxValid(RxValid), .RxReady(RxReady), .RxOverrun(RxOverrun),
        .Rx(rxLine), .Tx(Tx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        int waited = 0;
        while (TxReady !== 1'b1 && waited < 5000) begin
            @(negedge Clk);
            waited++;
        end
        checkOutput("tx_ready_wait", 32'(TxReady), 1);
        TxData  = data;
        TxValid = 1'b1;
        @(negedge Clk);
        TxValid = 1'b0;
    endtask

    task automatic waitTxFall(output int seen);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (Tx === 1'b0) begin
                seen = 1;
                break;
            end
        end
    endtask

    // Starts on the first low sample of Tx; index k is the k-th clock of the frame.
    task automatic measureFrame(output int lowCount, output int frameCount, output int bit9);
        int lowDone = 0;
        lowCount   = 0;
        frameCount = 0;
        bit9       = -1;
        while (TxBusy === 1'b1 && frameCount < 2000) begin
            if (lowDone == 0) begin
                if (Tx === 1'b0) lowCount++;
                else lowDone = 1;
            end
            if (frameCount == 64 * 9 + 32) bit9 = int'(Tx);
            frameCount++;
            @(negedge Clk);
        end
    endtask

    task automatic waitRxValid(output int seen);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (RxValid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic popRx();
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
    endtask

    task automatic driveRxFrame(input logic [7:0] data, input int nbits, input int sendPar,
                                input logic parBit, input logic stopBit);
        loopback = 1'b0;
        rxDrive  = 1'b0;
        repeat (64) @(negedge Clk);
        for (int i = 0; i < nbits; i++) begin
            rxDrive = data[i];
            repeat (64) @(negedge Clk);
        end
        if (sendPar != 0) begin
            rxDrive = parBit;
            repeat (64) @(negedge Clk);
        end
        rxDrive = stopBit;
        repeat (64) @(negedge Clk);
        rxDrive = 1'b1;
        repeat (128) @(negedge Clk);
    endtask

    initial begin
        int seen, lowCount, frameCount, bit9, baseOverrun, waited;

        repeat (5) @(negedge Clk);
        checkOutput("rst_tx", 32'(Tx), 1);
        checkOutput("rst_tx_ready", 32'(TxReady), 1);
        checkOutput("rst_tx_busy", 32'(TxBusy), 0);
        checkOutput("rst_rx_valid", 32'(RxValid), 0);
        checkOutput("rst_rx_data", 32'(RxData), 0);
        checkOutput("rst_flags", 32'({RxFrameErr, RxParErr, RxOverrun}), 0);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        NBits = 4'd8;
        applyStimulus(8'hA5);
        waitTxFall(seen);
        checkOutput("a5_start_seen", seen, 1);
        measureFrame(lowCount, frameCount, bit9);
        checkOutput("a5_start_len", lowCount, 64);
        checkOutput("a5_frame_len", frameCount, 640);
        waitRxValid(seen);
        checkOutput("a5_rx_valid", seen, 1);
        checkOutput("a5_rx_data", 32'(RxData), 32'hA5);
        checkOutput("a5_rx_flags", 32'({RxFrameErr, RxParErr}), 0);
        popRx();
        checkOutput("a5_rx_popped", 32'(RxValid), 0);

        applyStimulus(8'h0F);
        waitTxFall(seen);
        checkOutput("midrst_start_seen", seen, 1);
        repeat (100) @(negedge Clk);
        Rst_n = 1'b0;
        #2;
        checkOutput("midrst_tx", 32'(Tx), 1);
        checkOutput("midrst_tx_busy", 32'(TxBusy), 0);
        checkOutput("midrst_tx_ready", 32'(TxReady), 1);
        checkOutput("midrst_rx_valid", 32'(RxValid), 0);
        checkOutput("midrst_flags", 32'({RxFrameErr, RxParErr, RxOverrun}), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (1000) @(negedge Clk);
        checkOutput("midrst_no_rx_after", 32'(RxValid), 0);
        checkOutput("midrst_tx_idle_after", 32'(Tx), 1);

        for (int i = 0; i < 2; i++) begin
            NBits = (i == 0) ? 4'd5 : 4'd2;
            applyStimulus(8'hFF);
            waitTxFall(seen);
            checkOutput("nb5_start_seen", seen, 1);
            measureFrame(lowCount, frameCount, bit9);
            checkOutput("nb5_frame_len", frameCount, 448);
            waitRxValid(seen);
            checkOutput("nb5_rx_valid", seen, 1);
            checkOutput("nb5_rx_data", 32'(RxData), 32'h1F);
            popRx();
        end

        NBits = 4'd8;
        driveRxFrame(8'h3C, 8, 0, 1'b0, 1'b0);
        waitRxValid(seen);
        checkOutput("ferr_rx_valid", seen, 1);
        checkOutput("ferr_rx_data", 32'(RxData), 32'h3C);
        checkOutput("ferr_frame_err", 32'(RxFrameErr), 1);
        checkOutput("ferr_par_err", 32'(RxParErr), 0);
        popRx();

        rxDrive = 1'b0;
        repeat (16) @(negedge Clk);
        rxDrive = 1'b1;
        repeat (1500) @(negedge Clk);
        checkOutput("glitch_no_byte", 32'(RxValid), 0);
        loopback = 1'b1;

        ParEn  = 1'b1;
        ParOdd = 1'b0;
        applyStimulus(8'h03);
        waitTxFall(seen);
        checkOutput("par_start_seen", seen, 1);
        measureFrame(lowCount, frameCount, bit9);
        checkOutput("par_frame_len", frameCount, PAR_FRAME);
        checkOutput("par_bit9_level", bit9, BIT9_LEVEL);
        waitRxValid(seen);
        checkOutput("par_rx_valid", seen, 1);
        checkOutput("par_rx_data", 32'(RxData), 32'h03);
        checkOutput("par_rx_flags", 32'({RxFrameErr, RxParErr}), 0);
        popRx();
`ifdef UART_PARITY_EN
        driveRxFrame(8'h03, 8, 1, 1'b1, 1'b1);
        waitRxValid(seen);
        checkOutput("parerr_rx_valid", seen, 1);
        checkOutput("parerr_rx_data", 32'(RxData), 32'h03);
        checkOutput("parerr_par_err", 32'(RxParErr), 1);
        checkOutput("parerr_frame_err", 32'(RxFrameErr), 0);
        popRx();
        loopback = 1'b1;
`endif
        ParEn = 1'b0;

        baseOverrun = overrunCount;
        RxReady = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(8'(i));
        waited = 0;
        while (TxBusy === 1'b1 && waited < 20000) begin
            @(negedge Clk);
            waited++;
        end
        checkOutput("ovr_tx_done", 32'(TxBusy), 0);
        repeat (200) @(negedge Clk);
        checkOutput("ovr_pulse_count", overrunCount - baseOverrun, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("ovr_drain_valid", 32'(RxValid), 1);
            checkOutput("ovr_drain_data", 32'(RxData), i);
            popRx();
        end
        checkOutput("ovr_drain_empty", 32'(RxValid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
